// File: rtl/muldiv_unit_pkg.sv
// Shared op-code and state definitions for the M-extension unit.
// Imported by the iterative multiply/divide datapath.
package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } mdState_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step
// or a restoring-divide step over the {hi, lo} register pair.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            isDiv,
  input  logic [XLEN-1:0] hiIn,
  input  logic [XLEN-1:0] loIn,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hiOut,
  output logic [XLEN-1:0] loOut
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;
  logic            ge;

  // Multiply adds opnd when the multiplier LSB is set, then shifts
  // right; divide shifts the dividend in and keeps the subtraction
  // only when it does not go negative.
  always_comb begin
    sum     = {1'b0, hiIn} + (loIn[0] ? {1'b0, opnd} : '0);
    shifted = {hiIn, loIn[XLEN-1]};
    ge      = shifted >= {1'b0, opnd};
    diff    = shifted[XLEN-1:0] - opnd;
    if (isDiv) begin
      hiOut = ge ? diff : shifted[XLEN-1:0];
      loOut = {loIn[XLEN-2:0], ge};
    end else begin
      hiOut = sum[XLEN:1];
      loOut = {sum[0], loIn[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready intake,
// UNROLL steps per cycle and a one-cycle result strobe.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1,
  parameter int TAGW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [TAGW-1:0] in_tag,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST = CW'(N - 1);

  mdState_e        state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hiReg, loReg, opnd;
  logic [2:0]      opReg;
  logic            negRes, special;
  logic [TAGW-1:0] tagReg;
  logic [XLEN-1:0] outResult;
  logic [TAGW-1:0] outTag;
  logic            outValid;

  logic            signedA, signedB, aNeg, bNeg;
  logic [XLEN-1:0] aMag, bMag, specVal;
  logic            divZero, ovf, isSpecial, negIn;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] divVal, fixRes;
  logic [XLEN-1:0] stepHi, stepLo;

  assign in_ready   = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign out_valid  = outValid;
  assign out_result = outResult;
  assign out_tag    = outTag;

  // Operand decode at intake: magnitudes, result sign, special cases.
  always_comb begin
    signedA = (in_op == F3_MULH) | (in_op == F3_MULHSU) |
              (in_op == F3_DIV)  | (in_op == F3_REM);
    signedB = (in_op == F3_MULH) | (in_op == F3_DIV) |
              (in_op == F3_REM);
    aNeg    = signedA & in_a[XLEN-1];
    bNeg    = signedB & in_b[XLEN-1];
    aMag    = aNeg ? -in_a : in_a;
    bMag    = bNeg ? -in_b : in_b;
    negIn   = aNeg ^ (bNeg & ~(in_op[2] & in_op[1]));
    divZero = in_op[2] & (in_b == '0);
    ovf     = in_op[2] & ~in_op[0] & (in_a == MINV) & (in_b == '1);
    isSpecial = divZero | ovf;
    if (divZero) specVal = in_op[1] ? in_a : '1;
    else         specVal = in_op[1] ? '0 : in_a;
  end

  for (genvar i = 0; i < UNROLL; i++) begin : gStep
    logic [XLEN-1:0] hiIn, loIn, hiOut, loOut;
    if (i == 0) begin : gFirst
      assign hiIn = hiReg;
      assign loIn = loReg;
    end else begin : gNext
      assign hiIn = gStep[i-1].hiOut;
      assign loIn = gStep[i-1].loOut;
    end
    muldiv_step #(.XLEN(XLEN)) uStep (
      .isDiv(opReg[2]),
      .hiIn (hiIn),
      .loIn (loIn),
      .opnd (opnd),
      .hiOut(hiOut),
      .loOut(loOut)
    );
  end

  assign stepHi = gStep[UNROLL-1].hiOut;
  assign stepLo = gStep[UNROLL-1].loOut;

  // Sign correction and result selection applied in FIX.
  always_comb begin
    prod   = {hiReg, loReg};
    if (negRes) prod = -prod;
    divVal = opReg[1] ? hiReg : loReg;
    if (negRes) divVal = -divVal;
    if (special)        fixRes = loReg;
    else if (opReg[2])  fixRes = divVal;
    else if (opReg == F3_MUL) fixRes = prod[XLEN-1:0];
    else                fixRes = prod[2*XLEN-1:XLEN];
  end

  // Control FSM and datapath registers; reset beats flush beats accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      hiReg     <= '0;
      loReg     <= '0;
      opnd      <= '0;
      opReg     <= F3_MUL;
      negRes    <= 1'b0;
      special   <= 1'b0;
      tagReg    <= '0;
      outResult <= '0;
      outTag    <= '0;
      outValid  <= 1'b0;
    end else if (flush) begin
      state    <= S_IDLE;
      cnt      <= '0;
      outValid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          outValid <= 1'b0;
          if (in_valid) begin
            opReg   <= in_op;
            tagReg  <= in_tag;
            opnd    <= bMag;
            hiReg   <= '0;
            loReg   <= isSpecial ? specVal : aMag;
            negRes  <= negIn;
            special <= isSpecial;
            cnt     <= '0;
            state   <= isSpecial ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          hiReg <= stepHi;
          loReg <= stepLo;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) state <= S_FIX;
        end
        S_FIX: begin
          outResult <= fixRes;
          outTag    <= tagReg;
          outValid  <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          outValid <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Runs an UNROLL=1 and an UNROLL=4 instance side by side.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        inValid, inValid4;
  logic [2:0]  inOp;
  logic [31:0] inA, inB;
  logic [4:0]  inTag;

  logic        inReady, busy, outValid;
  logic [31:0] outResult;
  logic [4:0]  outTag;
  logic        inReady4, busy4, outValid4;
  logic [31:0] outResult4;
  logic [4:0]  outTag4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .UNROLL(1), .TAGW(5)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_op(inOp),
    .in_a(inA), .in_b(inB), .in_tag(inTag), .busy(busy),
    .out_valid(outValid), .out_result(outResult), .out_tag(outTag)
  );

  muldiv_unit #(.XLEN(32), .UNROLL(4), .TAGW(5)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid4), .in_ready(inReady4), .in_op(inOp),
    .in_a(inA), .in_b(inB), .in_tag(inTag), .busy(busy4),
    .out_valid(outValid4), .out_result(outResult4), .out_tag(outTag4)
  );

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic runOp(input bit u4, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp,
                       input int expLat, input string name);
    int lat;
    bit got;
    inOp = op; inA = a; inB = b; inTag = tag;
    if (u4) inValid4 = 1'b1;
    else    inValid  = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; inValid4 = 1'b0;
    inA = ~a; inB = a ^ b; inOp = ~op; inTag = ~tag;
    lat = 1;
    got = 1'b0;
    while (lat <= 100) begin
      if (u4 ? outValid4 : outValid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    checkVal({name, "_valid"}, 32'(got), 32'd1);
    checkVal({name, "_lat"}, 32'(lat), 32'(expLat));
    checkVal({name, "_res"}, u4 ? outResult4 : outResult, exp);
    checkVal({name, "_tag"}, 32'(u4 ? outTag4 : outTag), 32'(tag));
    @(posedge clk); #1;
    checkVal({name, "_strobe"}, 32'(u4 ? outValid4 : outValid), 32'd0);
    checkVal({name, "_hold"}, u4 ? outResult4 : outResult, exp);
  endtask

  initial begin
    int seen;
    reset = 1'b1; flush = 1'b0;
    inValid = 1'b0; inValid4 = 1'b0;
    inOp = '0; inA = '0; inB = '0; inTag = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    checkVal("rst_ready", 32'(inReady), 32'd1);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_valid", 32'(outValid), 32'd0);
    checkVal("rst_result", outResult, 32'd0);
    checkVal("rst_tag", 32'(outTag), 32'd0);

    runOp(0, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 34, "mul");
    runOp(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 34, "mulhu");
    runOp(0, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 32'h0, 34, "mulh");
    runOp(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF, 34, "mulhsu");
    runOp(0, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 34, "div");
    runOp(0, 3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 34, "rem");
    runOp(0, 3'b101, 32'h80000000, 32'd3, 5'd7, 32'h2AAAAAAA, 34, "divu");
    runOp(0, 3'b111, 32'd100, 32'd7, 5'd8, 32'd2, 34, "remu");
    runOp(0, 3'b100, 32'd1234, 32'd0, 5'd9, 32'hFFFFFFFF, 2, "divz");
    runOp(0, 3'b111, 32'd5, 32'd0, 5'd10, 32'd5, 2, "remuz");
    runOp(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 2, "divovf");
    runOp(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h0, 2, "removf");

    // flush wins over a simultaneous request while idle
    flush = 1'b1; inValid = 1'b1; inOp = 3'b000;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    checkVal("flushprio_ready", 32'(inReady), 32'd1);

    // flush five cycles into a divide
    inOp = 3'b100; inA = 32'd100; inB = 32'd3; inTag = 5'd13;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkVal("flush_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkVal("flush_ready", 32'(inReady), 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (outValid) seen++;
      @(posedge clk); #1;
    end
    checkVal("flush_novalid", 32'(seen), 32'd0);
    runOp(0, 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 34, "postflush");

    // reset in the middle of a multiply
    inOp = 3'b000; inA = 32'd5; inB = 32'd6; inTag = 5'd22;
    inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkVal("midrst_ready", 32'(inReady), 32'd1);
    checkVal("midrst_busy", 32'(busy), 32'd0);
    checkVal("midrst_valid", 32'(outValid), 32'd0);
    checkVal("midrst_result", outResult, 32'd0);
    checkVal("midrst_tag", 32'(outTag), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (outValid) seen++;
      @(posedge clk); #1;
    end
    checkVal("midrst_novalid", 32'(seen), 32'd0);

    runOp(1, 3'b000, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 10, "u4mul");
    runOp(1, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 10, "u4mulhu");
    runOp(1, 3'b100, 32'hFFFFFFF9, 32'd2, 5'd5, 32'hFFFFFFFD, 10, "u4div");
    runOp(1, 3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 32'hFFFFFFFF, 10, "u4rem");
    runOp(1, 3'b101, 32'h80000000, 32'd3, 5'd7, 32'h2AAAAAAA, 10, "u4divu");
    runOp(1, 3'b101, 32'd9, 32'd0, 5'd9, 32'hFFFFFFFF, 2, "u4divz");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width (even, at least 8).
REQ-002 SHALL have parameter UNROLL, default 1, meaning iteration steps per cycle (1, 2 or 4; must divide XLEN).
REQ-003 SHALL have parameter TAGW, default 5, meaning destination-register tag width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-005 SHALL have ports as follows:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  abort the current operation.
- in_valid  in  1  operation request.
- in_ready  out  1  unit idle and able to accept.
- in_op  in  3  RV32M funct3 code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- in_a  in  XLEN  rs1 operand.
- in_b  in  XLEN  rs2 operand.
- in_tag  in  TAGW  destination register.
- busy  out  1  equals ~in_ready; drives the pipeline stall.
- out_valid  out  1  one-cycle result strobe.
- out_result  out  XLEN  result.
- out_tag  out  TAGW  tag of the result.

Function
REQ-006 SHALL accept an operation on the rising edge where in_valid and in_ready are both high; in_ready SHALL be high only in state IDLE.
REQ-007 SHALL implement the states IDLE, CALC, FIX and DONE with the following transitions:
- IDLE to CALC on accept.
- IDLE to FIX on accept of a special-case divide.
- CALC to FIX after N=XLEN/UNROLL CALC cycles.
- FIX to DONE.
- DONE to IDLE.
REQ-008 SHALL latch operands, op and tag at accept; later changes to the inputs SHALL NOT affect the result.
REQ-009 SHALL convert signed operands to magnitudes at accept, per op signedness (MULHSU: a signed, b unsigned); FIX SHALL apply sign correction.
REQ-010 SHALL perform multiply as iterative shift-add over a 2*XLEN product, UNROLL bits per cycle; MUL SHALL return the low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits.
REQ-011 SHALL perform divide as restoring radix-2 divide, UNROLL quotient bits per cycle; the quotient SHALL take the sign a^b and the remainder the sign of a.
REQ-012 SHALL treat divide by zero as a special case: DIV/DIVU return all ones, REM/REMU return in_a.
REQ-013 SHALL treat signed overflow (in_a = -2^(XLEN-1), in_b = -1, DIV/REM) as a special case: DIV returns in_a, REM returns 0.
REQ-014 SHALL assert out_valid for exactly the one DONE cycle: N+2 cycles after the accept edge for the normal path, 2 cycles for special cases.
REQ-015 SHALL hold out_result and out_tag stable from DONE until the next accept.
REQ-016 SHALL, when flush is high on an edge in CALC, FIX or DONE, return to IDLE on that edge and not assert out_valid for the aborted operation.
REQ-017 SHALL give flush priority over accept when flush and in_valid are high in IDLE (no accept).
REQ-018 SHALL make busy combinational from state only, with no combinational path from in_valid.

Reset
REQ-019 SHALL give reset priority over flush and all other inputs.
REQ-020 SHALL, on reset, set state to IDLE, in_ready to 1, busy to 0, out_valid to 0, out_result to 0, out_tag to 0 and clear the iteration counter.
REQ-021 SHALL, on reset in mid-operation, discard the operation with no out_valid.

Structure
REQ-022 SHALL place the funct3 op-code constants and state encodings in the shared defines package beside the existing ALU/branch codes.
REQ-023 SHALL use one sub-module, muldiv_step, combinational, performing one shift-add or one restore-subtract step; it SHALL be instantiated UNROLL times in a chain.
REQ-024 SHALL contain no multiplier or divider operator in the RTL.

Verification
REQ-025 SHALL cover MUL with in_a=7, in_b=-3, XLEN=32, UNROLL=1 -> out_valid 34 cycles after accept, out_result=0xFFFFFFEB.
REQ-026 SHALL cover MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with -1 x -1 -> 0; MULHSU with -1 x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-027 SHALL cover DIV with -7 / 2 -> 0xFFFFFFFD; REM with -7 / 2 -> 0xFFFFFFFF; DIVU with 0x80000000 / 3 -> 0x2AAAAAAA.
REQ-028 SHALL cover DIV with x / 0 -> 0xFFFFFFFF and REMU with 5 / 0 -> 5, and DIV with 0x80000000 / -1 -> 0x80000000 and REM of the same -> 0, each with out_valid 2 cycles after accept.
REQ-029 SHALL cover flush asserted 5 cycles into DIV -> in_ready=1 next cycle, no out_valid, then a following MUL of 3 x 4 returns 12 with its own tag.
REQ-030 SHALL cover reset mid-CALC -> every output at its reset value on the next cycle; also UNROLL=4 -> latency 10 cycles with results matching UNROLL=1.
